// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: serialises scancode bytes into 11-bit frames on ps2_clk/ps2_data.
// Optional build macro PS2_TX_ERRINJ_EN adds err_inj to force a parity error on a chosen frame.
module ps2_kbd_tx #(
   parameter int HALF_PERIOD = 8,
   parameter int IDLE_GAP    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
`ifdef PS2_TX_ERRINJ_EN
   input  logic       err_inj,
`endif
   output logic       tx_ready,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy
);

   localparam int PW = $clog2(HALF_PERIOD) + 1;
   localparam int GW = $clog2(IDLE_GAP) + 1;
   localparam logic [PW-1:0] PH_LOAD  = PW'(HALF_PERIOD - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(IDLE_GAP - 1);
   localparam logic [3:0]    LAST_BIT = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_LOW,
      S_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [3:0]      bit_idx_q, bit_idx_d;
   logic [10:0]     shift_q, shift_d;
   logic            tx_ready_q, tx_ready_d;
   logic            busy_q, busy_d;
   logic            ps2_clk_q, ps2_clk_d;
   logic            ps2_data_q, ps2_data_d;

   logic            accept;
   logic            phase_done;
   logic            gap_done;
   logic            parity;

   assign accept     = tx_valid && tx_ready_q;
   assign phase_done = (phase_q == '0);
   assign gap_done   = (gap_q == '0);

`ifdef PS2_TX_ERRINJ_EN
   assign parity = ~(^tx_data) ^ err_inj;
`else
   assign parity = ~(^tx_data);
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept)     state_d = S_HIGH;
         S_HIGH: if (phase_done) state_d = S_LOW;
         S_LOW: begin
            if (phase_done) state_d = (bit_idx_q == LAST_BIT) ? S_GAP : S_HIGH;
         end
         S_GAP:  if (gap_done)   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Counters and frame shift register; the phase counter reloads on every state change
   always_comb begin
      phase_d   = phase_q;
      gap_d     = gap_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;

      if (state_d != state_q) begin
         phase_d = PH_LOAD;
      end else if ((state_q == S_HIGH) || (state_q == S_LOW)) begin
         phase_d = phase_q - 1'b1;
      end

      if ((state_d == S_GAP) && (state_q != S_GAP)) begin
         gap_d = GAP_LOAD;
      end else if ((state_q == S_GAP) && !gap_done) begin
         gap_d = gap_q - 1'b1;
      end

      if (accept) begin
         shift_d   = {1'b1, parity, tx_data, 1'b0};
         bit_idx_d = '0;
      end else if ((state_q == S_LOW) && phase_done && (bit_idx_q != LAST_BIT)) begin
         bit_idx_d = bit_idx_q + 1'b1;
      end
   end

   // Outputs are decoded from the next state so the registered lines line up with the state
   always_comb begin
      tx_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
      ps2_clk_d  = (state_d != S_LOW);
      ps2_data_d = 1'b1;
      if ((state_d == S_HIGH) || (state_d == S_LOW)) begin
         ps2_data_d = shift_d[bit_idx_d];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q    <= '0;
         gap_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
      end else begin
         phase_q    <= phase_d;
         gap_q      <= gap_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         ps2_clk_q  <= ps2_clk_d;
         ps2_data_q <= ps2_data_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;
   assign ps2_clk  = ps2_clk_q;
   assign ps2_data = ps2_data_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx: a host-side sampler decodes frames at ps2_clk falling edges.
module tb_ps2_kbd_tx;

   localparam int HP  = 8;
   localparam int GAP = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
`ifdef PS2_TX_ERRINJ_EN
   logic       err_inj = 1'b0;
`endif
   logic       tx_ready;
   logic       ps2_clk;
   logic       ps2_data;
   logic       busy;

   ps2_kbd_tx #(.HALF_PERIOD(HP), .IDLE_GAP(GAP)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
`ifdef PS2_TX_ERRINJ_EN
      .err_inj  (err_inj),
`endif
      .tx_ready (tx_ready),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Host model: samples data on each ps2_clk falling edge, validates start/parity/stop
   int         fall_cyc[$];
   logic       fall_bit[$];
   int         fall_gap[$];
   logic [7:0] rx_q[$];
   int         rx_bad = 0;
   logic       prev_clk = 1'b1;
   int         gap_cnt = 0;
   logic [10:0] sr = '0;
   int         nb = 0;

   always @(negedge clk) begin
      if (reset) begin
         prev_clk = 1'b1;
         nb = 0;
         gap_cnt = 0;
      end else begin
         if (prev_clk && !ps2_clk) begin
            fall_cyc.push_back(cyc);
            fall_bit.push_back(ps2_data);
            fall_gap.push_back(gap_cnt);
            gap_cnt = 0;
            sr[nb] = ps2_data;
            nb++;
            if (nb == 11) begin
               nb = 0;
               if (!sr[0] && sr[10] && (^sr[9:1])) rx_q.push_back(sr[8:1]);
               else rx_bad++;
            end
         end else if (ps2_clk && ps2_data && busy) begin
            gap_cnt++;
         end
         prev_clk = ps2_clk;
      end
   end

   task automatic clear_obs();
      fall_cyc.delete();
      fall_bit.delete();
      fall_gap.delete();
      rx_q.delete();
      rx_bad = 0;
   endtask

   task automatic send(input logic [7:0] d, input logic e, output int acc_c);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
`ifdef PS2_TX_ERRINJ_EN
      err_inj  = e;
`else
      if (e) $display("note: err_inj ignored in this build");
`endif
      for (int i = 0; i < 1000 && !tx_ready; i++) @(negedge clk);
      chk("send_ready", int'(tx_ready), 1);
      acc_c = cyc + 1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'hxx;
      chk("accepted_busy", int'(busy), 1);
   endtask

   task automatic wait_falls(input int n);
      for (int i = 0; i < 4000 && fall_cyc.size() < n; i++) @(negedge clk);
      chk("fall_count", fall_cyc.size(), n);
   endtask

   task automatic wait_ready(output int rc);
      for (int i = 0; i < 1000 && !tx_ready; i++) @(negedge clk);
      chk("ready_back", int'(tx_ready), 1);
      rc = cyc;
   endtask

   task automatic check_frame(input string tag, input int base, input logic [7:0] b,
                              input logic par, input int acc);
      logic [10:0] obs;
      logic [10:0] exp;
      obs = '0;
      exp = {1'b1, par, b, 1'b0};
      if (fall_bit.size() >= base + 11) begin
         for (int k = 0; k < 11; k++) obs[k] = fall_bit[base + k];
         chk({tag, "_frame"}, int'(obs), int'(exp));
         chk({tag, "_fall0"}, fall_cyc[base] - acc, HP);
         chk({tag, "_fall10"}, fall_cyc[base + 10] - acc, 21 * HP);
      end else begin
         chk({tag, "_frame_missing"}, fall_bit.size(), base + 11);
      end
   endtask

   int acc, acc2, rc;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_clk", int'(ps2_clk), 1);
      chk("rst_data", int'(ps2_data), 1);
      chk("rst_ready", int'(tx_ready), 0);
      chk("rst_busy", int'(busy), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", int'(tx_ready), 1);

      // 1: single 0x1C
      clear_obs();
      send(8'h1C, 1'b0, acc);
      wait_falls(11);
      check_frame("t1", 0, 8'h1C, 1'b0, acc);
      wait_ready(rc);
      chk("t1_ready_lat", rc - acc, 22 * HP + GAP);
      chk("t1_rx_n", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("t1_rx", int'(rx_q[0]), 8'h1C);

      // 2: back-to-back 0xF0, 0x1C with tx_valid held
      clear_obs();
      @(negedge clk);
      tx_data  = 8'hF0;
      tx_valid = 1'b1;
      for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
      acc = cyc + 1;
      @(negedge clk);
      tx_data = 8'h1C;
      for (int i = 0; i < 1000 && !tx_ready; i++) @(negedge clk);
      acc2 = cyc + 1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("t2_acc_dist", acc2 - acc, 22 * HP + GAP + 1);
      wait_falls(22);
      check_frame("t2a", 0, 8'hF0, 1'b1, acc);
      check_frame("t2b", 11, 8'h1C, 1'b0, acc2);
      if (fall_gap.size() > 11) chk("t2_gap", fall_gap[11], GAP);
      wait_ready(rc);
      chk("t2_rx_n", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         chk("t2_rx0", int'(rx_q[0]), 8'hF0);
         chk("t2_rx1", int'(rx_q[1]), 8'h1C);
      end
      chk("t2_bad", rx_bad, 0);

      // 3: 0x00 and 0xFF
      clear_obs();
      send(8'h00, 1'b0, acc);
      wait_falls(11);
      check_frame("t3a", 0, 8'h00, 1'b1, acc);
      wait_ready(rc);
      send(8'hFF, 1'b0, acc);
      wait_falls(22);
      check_frame("t3b", 11, 8'hFF, 1'b1, acc);
      wait_ready(rc);
      chk("t3_rx_n", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         chk("t3_rx0", int'(rx_q[0]), 8'h00);
         chk("t3_rx1", int'(rx_q[1]), 8'hFF);
      end

      // 4: reset at falling edge 5 of 0xA5, then 0x3A
      clear_obs();
      send(8'hA5, 1'b0, acc);
      wait_falls(6);
      chk("t4_clk_low", int'(ps2_clk), 0);
      reset = 1'b1;
      #1;
      chk("t4_async_clk", int'(ps2_clk), 1);
      chk("t4_async_data", int'(ps2_data), 1);
      chk("t4_ready_rst", int'(tx_ready), 0);
      repeat (3) @(negedge clk);
      chk("t4_ready_hold", int'(tx_ready), 0);
      chk("t4_busy_hold", int'(busy), 0);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("t4_no_rx", rx_q.size(), 0);
      clear_obs();
      send(8'h3A, 1'b0, acc);
      wait_falls(11);
      check_frame("t4", 0, 8'h3A, 1'b1, acc);
      wait_ready(rc);
      chk("t4_rx_n", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("t4_rx", int'(rx_q[0]), 8'h3A);

      // 5: tx_valid while busy is ignored
      clear_obs();
      send(8'h1C, 1'b0, acc);
      repeat (40) @(negedge clk);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_falls(11);
      check_frame("t5", 0, 8'h1C, 1'b0, acc);
      wait_ready(rc);
      repeat (60) @(negedge clk);
      chk("t5_falls", fall_cyc.size(), 11);
      chk("t5_rx_n", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("t5_rx", int'(rx_q[0]), 8'h1C);

`ifdef PS2_TX_ERRINJ_EN
      // 6: parity error injection on first frame only
      clear_obs();
      send(8'h1C, 1'b1, acc);
      wait_falls(11);
      check_frame("t6a", 0, 8'h1C, 1'b1, acc);
      wait_ready(rc);
      send(8'h1C, 1'b0, acc);
      wait_falls(22);
      check_frame("t6b", 11, 8'h1C, 1'b0, acc);
      wait_ready(rc);
      chk("t6_bad", rx_bad, 1);
      chk("t6_rx_n", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("t6_rx", int'(rx_q[0]), 8'h1C);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
